// File: rtl/fx_gbm_path_stepper.sv
// Geometric-Brownian-motion log-price path stepper: accumulates drift + vol*z per
// accepted z-score and emits each step's log-price tagged with its step index.
module fx_gbm_path_stepper #(
  parameter int WIDTH   = 32,
  parameter int QFRAC   = 16,
  parameter int N_STEPS = 64,
  parameter int STEP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  log_s0,
  input  logic signed [WIDTH-1:0]  drift_dt,
  input  logic signed [WIDTH-1:0]  vol_sqrt_dt,
  input  logic                     valid_in,
  input  logic signed [WIDTH-1:0]  z,
  output logic                     ready_out,
  output logic                     busy,
  output logic                     valid_out,
  output logic signed [WIDTH-1:0]  log_s,
  output logic [STEP_W-1:0]        step_idx,
  output logic                     path_done,
  output logic                     start_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [STEP_W-1:0]       LAST = STEP_W'(N_STEPS);
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  // Product path: floor-shift the full product, then clamp to WIDTH.
  function automatic logic signed [WIDTH-1:0] sat_prod(input logic signed [2*WIDTH-1:0] p);
    logic signed [2*WIDTH-1:0] sh;
    sh = p >>> QFRAC;
    if ((&sh[2*WIDTH-1:WIDTH-1]) || (~|sh[2*WIDTH-1:WIDTH-1]))
      return sh[WIDTH-1:0];
    else if (sh[2*WIDTH-1])
      return MINV;
    else
      return MAXV;
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_sum(input logic signed [WIDTH+1:0] s);
    if ((&s[WIDTH+1:WIDTH-1]) || (~|s[WIDTH+1:WIDTH-1]))
      return s[WIDTH-1:0];
    else if (s[WIDTH+1])
      return MINV;
    else
      return MAXV;
  endfunction

  state_t                    state, state_nxt;
  logic signed [WIDTH-1:0]   drift_lat, vol_lat, acc;
  logic [STEP_W-1:0]         acc_cnt, out_cnt;
  logic [STEP_W-1:0]         acc_cnt_inc, out_cnt_inc;
  logic                      accept, start_ok;
  logic signed [2*WIDTH-1:0] vol_x, z_x, prod_full;
  logic signed [WIDTH-1:0]   prod_p1;
  logic                      vld_p1;
  logic signed [WIDTH+1:0]   sum_p2;
  logic signed [WIDTH-1:0]   sum_sat_p2;

  assign ready_out   = (state == RUN);
  assign busy        = (state != IDLE);
  assign accept      = valid_in && ready_out;
  assign start_ok    = start && (state == IDLE);
  assign acc_cnt_inc = acc_cnt + 1'b1;
  assign out_cnt_inc = out_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && (acc_cnt_inc == LAST)) state_nxt = DRAIN;
      DRAIN:   if (path_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Path control: coefficient latch, accept counter, busy-start flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drift_lat <= '0;
      vol_lat   <= '0;
      acc_cnt   <= '0;
      start_err <= 1'b0;
    end else begin
      start_err <= start && (state != IDLE);
      if (start_ok) begin
        drift_lat <= drift_dt;
        vol_lat   <= vol_sqrt_dt;
        acc_cnt   <= '0;
      end else if (accept) begin
        acc_cnt   <= acc_cnt_inc;
      end
    end
  end

  assign vol_x     = {{WIDTH{vol_lat[WIDTH-1]}}, vol_lat};
  assign z_x       = {{WIDTH{z[WIDTH-1]}}, z};
  assign prod_full = vol_x * z_x;

  // Stage 1: scaled diffusion term vol*z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) prod_p1 <= sat_prod(prod_full);
    end
  end

  assign sum_p2 = {{2{acc[WIDTH-1]}}, acc} + {{2{drift_lat[WIDTH-1]}}, drift_lat}
                + {{2{prod_p1[WIDTH-1]}}, prod_p1};
  assign sum_sat_p2 = sat_sum(sum_p2);

  // Stage 2: accumulate into the log-price and publish the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_cnt   <= '0;
      log_s     <= '0;
      step_idx  <= '0;
      valid_out <= 1'b0;
      path_done <= 1'b0;
    end else begin
      valid_out <= vld_p1;
      path_done <= vld_p1 && (out_cnt_inc == LAST);
      if (start_ok) begin
        acc     <= log_s0;
        out_cnt <= '0;
      end else if (vld_p1) begin
        acc      <= sum_sat_p2;
        log_s    <= sum_sat_p2;
        out_cnt  <= out_cnt_inc;
        step_idx <= out_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_fx_gbm_path_stepper.sv
// Scoreboard bench for fx_gbm_path_stepper: a 4-step and a 1-step instance driven
// with directed and random paths, checked against an arithmetic path model.
module tb_fx_gbm_path_stepper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [31:0] log_s0, drift_dt, vol_sqrt_dt, z;
  logic               start_v [2];
  logic               valid_v [2];
  logic               ready_v [2];
  logic               busy_v  [2];
  logic               vout_v  [2];
  logic               done_v  [2];
  logic               serr_v  [2];
  logic signed [31:0] ls_v    [2];
  logic [7:0]         si_v    [2];

  fx_gbm_path_stepper #(.WIDTH(32), .QFRAC(16), .N_STEPS(4), .STEP_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .log_s0(log_s0), .drift_dt(drift_dt),
    .vol_sqrt_dt(vol_sqrt_dt), .valid_in(valid_v[0]), .z(z), .ready_out(ready_v[0]),
    .busy(busy_v[0]), .valid_out(vout_v[0]), .log_s(ls_v[0]), .step_idx(si_v[0]),
    .path_done(done_v[0]), .start_err(serr_v[0]));

  fx_gbm_path_stepper #(.WIDTH(32), .QFRAC(16), .N_STEPS(1), .STEP_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .log_s0(log_s0), .drift_dt(drift_dt),
    .vol_sqrt_dt(vol_sqrt_dt), .valid_in(valid_v[1]), .z(z), .ready_out(ready_v[1]),
    .busy(busy_v[1]), .valid_out(vout_v[1]), .log_s(ls_v[1]), .step_idx(si_v[1]),
    .path_done(done_v[1]), .start_err(serr_v[1]));

  typedef struct {
    longint ls;
    int     step;
    int     done;
    int     cyc;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     done_cyc [2];
  longint m_acc [2];
  longint m_drift [2];
  longint m_vol [2];
  int     m_step [2];
  int     nst [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // One GBM step: log_s' = log_s + drift + floor(vol*z / 2^16), each stage clamped.
  function automatic longint ref_step(input longint a, input longint d, input longint v,
                                      input longint zz);
    longint p;
    p = sat32((v * zz) >>> 16);
    return sat32(a + d + p);
  endfunction

  // Monitor: pops the scoreboard whenever a DUT presents an output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (vout_v[s] || done_v[s]) begin
          if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
            check("unexpected_output", vout_v[s], 0);
          end else begin
            e = (s == 0) ? q0.pop_front() : q1.pop_front();
            check("valid_out", vout_v[s], 1);
            check("log_s", ls_v[s], e.ls);
            check("step_idx", si_v[s], e.step);
            check("path_done", done_v[s], e.done);
            check("latency", cyc, e.cyc);
            if (done_v[s]) done_cyc[s] = cyc;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int s);
    check("rst_log_s", ls_v[s], 0);
    check("rst_step_idx", si_v[s], 0);
    check("rst_flags", {ready_v[s], busy_v[s], vout_v[s], done_v[s], serr_v[s]}, 0);
  endtask

  task automatic do_start(input int s, input logic signed [31:0] s0,
                          input logic signed [31:0] dr, input logic signed [31:0] vol);
    log_s0 = s0;
    drift_dt = dr;
    vol_sqrt_dt = vol;
    m_acc[s] = s0;
    m_drift[s] = dr;
    m_vol[s] = vol;
    m_step[s] = 0;
    start_v[s] = 1'b1;
    tick();
    start_v[s] = 1'b0;
    log_s0 = $urandom;
    drift_dt = $urandom;
    vol_sqrt_dt = $urandom;
    check("busy_after_start", busy_v[s], 1);
  endtask

  task automatic feed(input int s, input logic signed [31:0] zv, input int gap,
                      input bit also_start);
    exp_t e;
    repeat (gap) tick();
    check("ready_run", ready_v[s], 1);
    valid_v[s] = 1'b1;
    z = zv;
    if (also_start) begin
      start_v[s] = 1'b1;
      log_s0 = $urandom;
    end
    m_acc[s] = ref_step(m_acc[s], m_drift[s], m_vol[s], longint'(zv));
    m_step[s]++;
    e.ls = m_acc[s];
    e.step = m_step[s];
    e.done = (m_step[s] == nst[s]) ? 1 : 0;
    e.cyc = cyc + 2;
    if (s == 0) q0.push_back(e);
    else q1.push_back(e);
    tick();
    valid_v[s] = 1'b0;
    start_v[s] = 1'b0;
    z = $urandom;
    if (also_start) check("start_err", serr_v[s], 1);
    if (m_step[s] == nst[s]) check("ready_drain", ready_v[s], 0);
  endtask

  task automatic wait_idle(input int s);
    int n;
    n = 0;
    while (busy_v[s] && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("idle_timeout", busy_v[s], 0);
    else check("busy_drop_cycle", cyc, done_cyc[s] + 1);
  endtask

  function automatic logic signed [31:0] rand_z();
    int zi;
    if ($urandom_range(0, 7) == 0) return $urandom;
    zi = int'($urandom_range(0, 524288)) - 262144;
    return zi;
  endfunction

  initial begin
    int n;
    logic signed [31:0] zs [4];
    nst[0] = 4;
    nst[1] = 1;
    done_cyc[0] = -10;
    done_cyc[1] = -10;
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0;
      valid_v[s] = 1'b0;
    end
    log_s0 = '0;
    drift_dt = '0;
    vol_sqrt_dt = '0;
    z = '0;
    repeat (3) tick();
    check_zero(0);
    check_zero(1);
    rst_n = 1'b1;
    tick();

    // z offered while idle must be dropped
    valid_v[0] = 1'b1;
    z = 32'sd65536;
    tick();
    check("idle_ready", ready_v[0], 0);
    tick();
    valid_v[0] = 1'b0;
    repeat (3) tick();
    check("idle_busy", busy_v[0], 0);

    // single-step path
    do_start(1, 32'sd301805, 32'sd66, 32'sd1311);
    feed(1, 32'sd65536, 0, 1'b0);
    wait_idle(1);

    // full path, back-to-back then gapped
    zs[0] = 32'sd65536; zs[1] = -32'sd65536; zs[2] = 32'sd0; zs[3] = 32'sd32768;
    do_start(0, 32'sd301805, 32'sd66, 32'sd1311);
    for (int i = 0; i < 4; i++) feed(0, zs[i], 0, 1'b0);
    wait_idle(0);
    do_start(0, 32'sd301805, 32'sd66, 32'sd1311);
    for (int i = 0; i < 4; i++) feed(0, zs[i], int'($urandom_range(1, 3)), 1'b0);
    wait_idle(0);

    // saturation, both directions
    do_start(0, 32'h7FFF0000, 32'h00010000, 32'h00010000);
    for (int i = 0; i < 4; i++) feed(0, 32'h00100000, 0, 1'b0);
    wait_idle(0);
    do_start(0, 32'h80010000, -32'sh00010000, 32'h00010000);
    for (int i = 0; i < 4; i++) feed(0, -32'sh00100000, 0, 1'b0);
    wait_idle(0);
    do_start(0, 32'sd0, 32'sd0, 32'h7FFFFFFF);
    feed(0, 32'h7FFFFFFF, 0, 1'b0);
    feed(0, 32'h80000000, 0, 1'b0);
    feed(0, 32'h80000000, 0, 1'b0);
    feed(0, 32'h7FFFFFFF, 0, 1'b0);
    wait_idle(0);

    // start while busy must not disturb the path
    do_start(0, 32'sd301805, 32'sd66, 32'sd1311);
    for (int i = 0; i < 4; i++) feed(0, zs[i], 0, (i == 1));
    wait_idle(0);

    // asynchronous reset after step 2 of 4
    do_start(0, 32'sd301805, 32'sd66, 32'sd1311);
    feed(0, zs[0], 0, 1'b0);
    feed(0, zs[1], 0, 1'b0);
    n = 0;
    while (q0.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) check("pre_reset_timeout", q0.size(), 0);
    rst_n = 1'b0;
    #1;
    check_zero(0);
    q0.delete();
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_reset_busy", busy_v[0], 0);
    do_start(0, 32'sd123456, 32'sd66, 32'sd1311);
    for (int i = 0; i < 4; i++) feed(0, zs[i], 0, 1'b0);
    wait_idle(0);

    // random paths on both instances
    for (int p = 0; p < 8; p++) begin
      do_start(0, $urandom, int'($urandom_range(0, 4000)) - 2000, $urandom_range(0, 20000));
      for (int i = 0; i < 4; i++) feed(0, rand_z(), int'($urandom_range(0, 2)), 1'b0);
      wait_idle(0);
      do_start(1, $urandom, int'($urandom_range(0, 4000)) - 2000, $urandom);
      feed(1, rand_z(), int'($urandom_range(0, 2)), 1'b0);
      wait_idle(1);
    end

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("drain_timeout", q0.size() + q1.size(), 0);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
